fuzz_vector_sequencer: RTL

- Drives a synthesized fuzz DUT through a fixed-length list of random stimulus vectors. Captures the DUT output for each vector and compares it against a golden output stream from the reference simulator run.
- Sits between the stimulus/golden memories and the DUT inputs (wire3, wire2, wire1, wire0).
- Replaces the open-loop #10 stimulus with a clocked, handshaked, self-checking loop that reports mismatch count and first failing index.

---
 rtl/fuzz_vector_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fuzz_vector_sequencer.sv
// Clocked, handshaked sequencer for a fuzz DUT: fetches each stimulus vector,
// holds it on the DUT, captures the output and scores it against the golden word.
module fuzz_vector_sequencer #(
   parameter int IN_W    = 64,
   parameter int OUT_W   = 166,
   parameter int NUM_VEC = 21,
   parameter int HOLD    = 1,
   parameter int TIMEOUT = 16,
   localparam int AW     = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             vec_req,
   output logic [AW-1:0]    vec_addr,
   input  logic             vec_valid,
   input  logic [IN_W-1:0]  vec_data,
   output logic             gold_req,
   input  logic             gold_valid,
   input  logic [OUT_W-1:0] gold_data,
   output logic [IN_W-1:0]  dut_in,
   input  logic [OUT_W-1:0] dut_y,
   output logic             busy,
   output logic             done,
   output logic             err_timeout,
   output logic [15:0]      mism_cnt,
   output logic [AW-1:0]    first_mism
);

   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_VEC - 1);
   localparam logic [HW-1:0] HOLD_LD   = HW'(HOLD - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_APPLY, S_CAPTURE, S_GOLD, S_NEXT, S_FIN
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [AW-1:0]      r_idx;
   logic [HW-1:0]      r_hold;
   logic [WW-1:0]      r_wait;
   logic               r_busy;
   logic               r_err;
   logic [15:0]        r_mism_cnt;
   logic [AW-1:0]      r_first;
   logic [IN_W-1:0]    r_dut_in;
   logic [OUT_W-1:0]   r_cap_y;
   logic               w_wait_exp;
   logic               w_match;

   // r_wait counts cycles spent in the current FETCH/GOLD wait; expiry on the
   // same edge as a valid loses to the valid.
   assign w_wait_exp = (r_wait == WAIT_LAST);
   assign w_match    = (r_cap_y == gold_data);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (start) w_state_nxt = S_FETCH;
         S_FETCH: begin
            if (vec_valid)       w_state_nxt = S_APPLY;
            else if (w_wait_exp) w_state_nxt = S_FIN;
         end
         S_APPLY:   if (r_hold == '0) w_state_nxt = S_CAPTURE;
         S_CAPTURE: w_state_nxt = S_GOLD;
         S_GOLD: begin
            if (gold_valid)      w_state_nxt = S_NEXT;
            else if (w_wait_exp) w_state_nxt = S_FIN;
         end
         S_NEXT:    w_state_nxt = (r_idx == LAST_IDX) ? S_FIN : S_FETCH;
         S_FIN:     w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx      <= '0;
         r_hold     <= '0;
         r_wait     <= '0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
         r_mism_cnt <= '0;
         r_first    <= '0;
         r_dut_in   <= '0;
      end else begin
         if (r_state == S_FETCH || r_state == S_GOLD) r_wait <= r_wait + 1'b1;
         else                                         r_wait <= '0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_idx      <= '0;
                  r_mism_cnt <= '0;
                  r_first    <= '0;
                  r_err      <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            S_FETCH: begin
               if (vec_valid) begin
                  r_dut_in <= vec_data;
                  r_hold   <= HOLD_LD;
               end else if (w_wait_exp) begin
                  r_err <= 1'b1;
               end
            end
            S_APPLY: if (r_hold != '0) r_hold <= r_hold - 1'b1;
            S_GOLD: begin
               if (gold_valid) begin
                  // Written as if/else so an X compare lands in the mismatch branch.
                  if (w_match) begin
                     r_mism_cnt <= r_mism_cnt;
                  end else begin
                     if (r_mism_cnt != 16'hFFFF) r_mism_cnt <= r_mism_cnt + 16'd1;
                     if (r_mism_cnt == 16'd0)    r_first    <= r_idx;
                  end
               end else if (w_wait_exp) begin
                  r_err <= 1'b1;
               end
            end
            S_NEXT:  if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
            S_FIN:   r_busy <= 1'b0;
            default: r_busy <= r_busy;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == S_CAPTURE) r_cap_y <= dut_y;
   end

   assign vec_req     = (r_state == S_FETCH);
   assign gold_req    = (r_state == S_GOLD);
   assign done        = (r_state == S_FIN);
   assign vec_addr    = r_idx;
   assign dut_in      = r_dut_in;
   assign busy        = r_busy;
   assign err_timeout = r_err;
   assign mism_cnt    = r_mism_cnt;
   assign first_mism  = r_first;

endmodule
